rom_sequencer: RTL and testbench
================================

ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width, 1..32.
REQ-002 Parameter ADDR_WIDTH, default 3: address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter MODE, default 0: content generator; 0 one-hot, 1 thermometer, 2 binary index.
REQ-004 Parameter STEP_CYCLES, default 1: clock cycles each playback word is held, >=1.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-007 rd_en  in  1  random-read request, sampled each rising edge.
REQ-008 rd_addr  in  ADDR_WIDTH  random-read address.
REQ-009 rd_data  out  DATA_WIDTH  registered random-read word.
REQ-010 rd_valid  out  1  one-cycle pulse: rd_data updated.
REQ-011 start  in  1  playback request; honoured only when busy=0.
REQ-012 length  in  ADDR_WIDTH+1  number of words to play, captured with start.
REQ-013 abort  in  1  stop playback immediately, no done.
REQ-014 play_data  out  DATA_WIDTH  current playback word.
REQ-015 play_valid  out  1  one-cycle pulse: new word on play_data.
REQ-016 busy  out  1  playback in progress.
REQ-017 done  out  1  one-cycle pulse: playback completed normally.

Function
REQ-018 Content rom[a], a in 0..DEPTH-1, k = a mod DATA_WIDTH: MODE 0 -> only bit k set; MODE 1 -> bits 0..k set; MODE 2 -> a zero-extended/truncated to DATA_WIDTH.
REQ-019 Random read: rd_en=1 at edge T -> rd_data=rom[rd_addr] and rd_valid=1 after edge T; rd_valid=0 after any edge with rd_en=0; rd_data otherwise holds.
REQ-020 Random-read port independent of playback; both may operate in the same cycle with no stall.
REQ-021 FSM states IDLE, PLAY; busy=1 exactly in PLAY.
REQ-022 IDLE, start=1, length>=1 at edge T: effective len = min(length, DEPTH) latched; index<=0; play_data<=rom[0]; play_valid<=1; hold counter<=STEP_CYCLES-1; go PLAY.
REQ-023 IDLE, start=1, length=0: stay IDLE, done=1 for one cycle, play_data unchanged, no play_valid.
REQ-024 PLAY, counter>0: counter decrements, play_valid=0.
REQ-025 PLAY, counter=0, index<len-1: index++, play_data<=rom[index+1], play_valid=1, counter<=STEP_CYCLES-1.
REQ-026 PLAY, counter=0, index=len-1: done=1 one cycle, go IDLE; play_data holds last word.
REQ-027 Timing: word k appears after edge T+k*STEP_CYCLES; done after edge T+len*STEP_CYCLES.
REQ-028 start while busy=1 ignored; length changes after capture have no effect.
REQ-029 abort=1 in PLAY: next edge to IDLE, busy=0, no done, no play_valid; play_data holds. abort has priority over REQ-025/026 in the same cycle.
REQ-030 abort in IDLE ignored; start and abort together in IDLE -> abort wins, no playback.
REQ-031 start sampled in the same cycle done is asserted is honoured on the following edge only (back-to-back restart gap of one cycle).

Reset
REQ-032 reset=0: immediately rd_data=0, rd_valid=0, play_data=0, play_valid=0, busy=0, done=0, state IDLE, index=0, counter=0.
REQ-033 Reset asserted mid-playback aborts without done; after release, first edge behaves as IDLE.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, MODE=0 unless stated)
REQ-034 Reset release, idle 5 cycles -> all outputs 0, busy=0.
REQ-035 rd_en with rd_addr=5 -> next cycle rd_data=8'h20, rd_valid=1 one cycle; MODE=1, rd_addr=3 -> rd_data=8'h0F.
REQ-036 STEP_CYCLES=4, start with length=3 at edge T -> play_data 8'h01,8'h02,8'h04 after T,T+4,T+8; done after T+12; busy high T..T+11.
REQ-037 STEP_CYCLES=1, length=12 -> 8 words 8'h01..8'h80 consecutive, done after 8th; length=0 -> done only.
REQ-038 STEP_CYCLES=4, length=8, abort after word 2 -> busy falls next edge, no done, play_data stays 8'h04; start during playback ignored.
REQ-039 reset=0 during playback (word 3) -> all outputs 0 asynchronously; new start after release plays from rom[0].

Source files
------------

// File: rtl/rom_sequencer_if.sv
// Bus bundle for rom_sequencer: random-read port plus playback control/status.
// The master drives requests, and the slave (the sequencer) drives data and status.
interface rom_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  start;
    logic [ADDR_WIDTH:0]   length;
    logic                  abort;
    logic [DATA_WIDTH-1:0] play_data;
    logic                  play_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output rd_en, rd_addr, start, length, abort,
        input  rd_data, rd_valid, play_data, play_valid, busy, done
    );

    modport slave (
        input  rd_en, rd_addr, start, length, abort,
        output rd_data, rd_valid, play_data, play_valid, busy, done
    );
endinterface

// File: rtl/rom_sequencer.sv
// Constant-content ROM with a registered random-read port and an independent
// playback engine that streams rom[0..len-1], holding each word STEP_CYCLES clocks.
module rom_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int MODE        = 0,
    parameter int STEP_CYCLES = 1
) (
    input  logic           clock,
    input  logic           reset,
    rom_sequencer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [DATA_WIDTH-1:0] rom [DEPTH];

    genvar gi, gb;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam int K = gi % DATA_WIDTH;
            logic [DATA_WIDTH-1:0] word;
            for (gb = 0; gb < DATA_WIDTH; gb++) begin : g_bit
                if (MODE == 0) begin : g_onehot
                    assign word[gb] = (gb == K);
                end else if (MODE == 1) begin : g_therm
                    assign word[gb] = (gb <= K);
                end else begin : g_index
                    assign word[gb] = (((gi >> gb) & 1) != 0);
                end
            end
            assign rom[gi] = word;
        end
    endgenerate

    // Random-read port: fully independent of the playback FSM.
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_reg <= rom[bus.rd_addr];
            end
        end
    end

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   len_reg, len_next;
    logic [ADDR_WIDTH-1:0] index_reg, index_next;
    logic [CNT_W-1:0]      counter_reg, counter_next;
    logic [DATA_WIDTH-1:0] play_data_reg, play_data_next;
    logic                  play_valid_reg, play_valid_next;
    logic                  done_reg, done_next;
    logic [ADDR_WIDTH-1:0] index_inc;

    assign index_inc = index_reg + ADDR_WIDTH'(1);

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        index_next      = index_reg;
        counter_next    = counter_reg;
        play_data_next  = play_data_reg;
        play_valid_next = 1'b0;
        done_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                // abort alongside start suppresses the request entirely
                if (bus.start && !bus.abort) begin
                    if (bus.length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        len_next        = (bus.length > DEPTH_LEN) ? DEPTH_LEN : bus.length;
                        index_next      = '0;
                        play_data_next  = rom[0];
                        play_valid_next = 1'b1;
                        counter_next    = CNT_LOAD;
                        state_next      = PLAY;
                    end
                end
            end
            PLAY: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (counter_reg != '0) begin
                    counter_next = counter_reg - CNT_W'(1);
                end else if ({1'b0, index_reg} != len_reg - (ADDR_WIDTH + 1)'(1)) begin
                    index_next      = index_inc;
                    play_data_next  = rom[index_inc];
                    play_valid_next = 1'b1;
                    counter_next    = CNT_LOAD;
                end else begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            index_reg      <= '0;
            counter_reg    <= '0;
            play_data_reg  <= '0;
            play_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            index_reg      <= index_next;
            counter_reg    <= counter_next;
            play_data_reg  <= play_data_next;
            play_valid_reg <= play_valid_next;
            done_reg       <= done_next;
        end
    end

    assign bus.rd_data    = rd_data_reg;
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.play_data  = play_data_reg;
    assign bus.play_valid = play_valid_reg;
    assign bus.busy       = (state_reg == PLAY);
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer: four instances cover MODE 0/1/2 and
// STEP_CYCLES 1/4; expected values are hand-computed constants.
module tb_rom_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total  = 0;
    int   passed = 0;

    always #5 clock = ~clock;

    rom_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifa ();
    rom_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifb ();
    rom_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifc ();
    rom_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ifd ();

    rom_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .MODE(0), .STEP_CYCLES(4))
        dut_a (.clock(clock), .reset(reset), .bus(ifa));
    rom_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .MODE(0), .STEP_CYCLES(1))
        dut_b (.clock(clock), .reset(reset), .bus(ifb));
    rom_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .MODE(1), .STEP_CYCLES(1))
        dut_c (.clock(clock), .reset(reset), .bus(ifc));
    rom_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .MODE(2), .STEP_CYCLES(1))
        dut_d (.clock(clock), .reset(reset), .bus(ifd));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic [7:0] exp_word;
        ifa.rd_en = 0; ifa.rd_addr = 0; ifa.start = 0; ifa.length = 0; ifa.abort = 0;
        ifb.rd_en = 0; ifb.rd_addr = 0; ifb.start = 0; ifb.length = 0; ifb.abort = 0;
        ifc.rd_en = 0; ifc.rd_addr = 0; ifc.start = 0; ifc.length = 0; ifc.abort = 0;
        ifd.rd_en = 0; ifd.rd_addr = 0; ifd.start = 0; ifd.length = 0; ifd.abort = 0;

        // reset held, then released and idle for 5 cycles
        step(1);
        chk("rst_rd_data", ifa.rd_data, 0);
        chk("rst_play_data", ifa.play_data, 0);
        chk("rst_busy", ifa.busy, 0);
        @(negedge clock);
        reset = 1'b1;
        step(5);
        chk("idle_rd_data", ifa.rd_data, 0);
        chk("idle_rd_valid", ifa.rd_valid, 0);
        chk("idle_play_data", ifa.play_data, 0);
        chk("idle_play_valid", ifa.play_valid, 0);
        chk("idle_busy", ifa.busy, 0);
        chk("idle_done", ifa.done, 0);

        // random reads in all three content modes
        ifa.rd_en = 1; ifa.rd_addr = 5;
        ifc.rd_en = 1; ifc.rd_addr = 3;
        ifd.rd_en = 1; ifd.rd_addr = 6;
        step(1);
        chk("rd_m0_data", ifa.rd_data, 8'h20);
        chk("rd_m0_valid", ifa.rd_valid, 1);
        chk("rd_m1_data", ifc.rd_data, 8'h0F);
        chk("rd_m2_data", ifd.rd_data, 8'h06);
        chk("rd_other_valid", ifb.rd_valid, 0);
        ifa.rd_en = 0; ifc.rd_en = 0; ifd.rd_en = 0;
        step(1);
        chk("rd_valid_pulse", ifa.rd_valid, 0);
        chk("rd_data_hold", ifa.rd_data, 8'h20);

        // STEP_CYCLES=4, length=3, with a concurrent random read
        ifa.start = 1; ifa.length = 3;
        step(1);
        ifa.start = 0; ifa.length = 7;
        chk("p4_w0_data", ifa.play_data, 8'h01);
        chk("p4_w0_valid", ifa.play_valid, 1);
        chk("p4_w0_busy", ifa.busy, 1);
        chk("p4_w0_done", ifa.done, 0);
        step(1);
        chk("p4_hold_valid", ifa.play_valid, 0);
        chk("p4_hold_data", ifa.play_data, 8'h01);
        ifa.rd_en = 1; ifa.rd_addr = 7;
        step(3);
        ifa.rd_en = 0;
        chk("p4_w1_data", ifa.play_data, 8'h02);
        chk("p4_w1_valid", ifa.play_valid, 1);
        chk("p4_conc_rd_data", ifa.rd_data, 8'h80);
        chk("p4_conc_rd_valid", ifa.rd_valid, 1);
        step(4);
        chk("p4_w2_data", ifa.play_data, 8'h04);
        chk("p4_w2_valid", ifa.play_valid, 1);
        step(3);
        chk("p4_t11_busy", ifa.busy, 1);
        chk("p4_t11_done", ifa.done, 0);
        step(1);
        chk("p4_t12_done", ifa.done, 1);
        chk("p4_t12_busy", ifa.busy, 0);
        chk("p4_t12_data", ifa.play_data, 8'h04);
        chk("p4_t12_valid", ifa.play_valid, 0);
        step(1);
        chk("p4_done_pulse", ifa.done, 0);

        // STEP_CYCLES=1, length=12 clamps to 8 words
        ifb.start = 1; ifb.length = 12;
        step(1);
        ifb.start = 0;
        for (int k = 0; k < 8; k++) begin
            exp_word = 8'(1 << k);
            chk($sformatf("p1_w%0d_data", k), ifb.play_data, exp_word);
            chk($sformatf("p1_w%0d_valid", k), ifb.play_valid, 1);
            if (k < 7) step(1);
        end
        step(1);
        chk("p1_done", ifb.done, 1);
        chk("p1_done_busy", ifb.busy, 0);
        chk("p1_last_hold", ifb.play_data, 8'h80);
        // restart request in the done cycle, with length=0
        ifb.start = 1; ifb.length = 0;
        step(1);
        ifb.start = 0;
        chk("len0_done", ifb.done, 1);
        chk("len0_busy", ifb.busy, 0);
        chk("len0_valid", ifb.play_valid, 0);
        chk("len0_data", ifb.play_data, 8'h80);
        step(1);
        chk("len0_done_pulse", ifb.done, 0);

        // abort after word 2, with an ignored start during playback
        ifa.start = 1; ifa.length = 8;
        step(1);
        ifa.start = 0;
        step(8);
        chk("ab_w2_data", ifa.play_data, 8'h04);
        ifa.start = 1; ifa.length = 2;
        step(1);
        chk("ab_start_ign_busy", ifa.busy, 1);
        chk("ab_start_ign_valid", ifa.play_valid, 0);
        chk("ab_start_ign_data", ifa.play_data, 8'h04);
        step(2);
        ifa.start = 0; ifa.abort = 1;
        step(1);
        chk("ab_busy", ifa.busy, 0);
        chk("ab_done", ifa.done, 0);
        chk("ab_valid", ifa.play_valid, 0);
        chk("ab_data", ifa.play_data, 8'h04);
        // start and abort together in IDLE
        ifa.start = 1; ifa.length = 3;
        step(1);
        chk("ab_idle_busy", ifa.busy, 0);
        chk("ab_idle_valid", ifa.play_valid, 0);
        chk("ab_idle_done", ifa.done, 0);
        ifa.start = 0; ifa.abort = 0;
        step(1);

        // asynchronous reset during playback word 3
        ifb.start = 1; ifb.length = 8;
        step(1);
        ifb.start = 0;
        step(3);
        chk("rr_w3_data", ifb.play_data, 8'h08);
        #2;
        reset = 1'b0;
        #1;
        chk("rr_async_data", ifb.play_data, 0);
        chk("rr_async_busy", ifb.busy, 0);
        chk("rr_async_valid", ifb.play_valid, 0);
        chk("rr_async_rd_data", ifa.rd_data, 0);
        @(negedge clock);
        reset = 1'b1;
        ifb.start = 1; ifb.length = 2;
        step(1);
        ifb.start = 0;
        chk("rr_new_w0_data", ifb.play_data, 8'h01);
        chk("rr_new_w0_busy", ifb.busy, 1);
        step(1);
        chk("rr_new_w1_data", ifb.play_data, 8'h02);
        step(1);
        chk("rr_new_done", ifb.done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
